// File: rtl/waves_nios_switch_ctrl.sv
// waves_nios_switch_ctrl
// Avalon-MM slave front-end for the board slide switches. Each raw switch bit
// is brought into the clock domain with a two-flop synchroniser and then
// debounced by a per-bit hold counter. Any accepted level change (rising or
// falling) is latched in a write-1-to-clear edge-capture register. A maskable,
// level-sensitive interrupt is raised towards the Nios II.
//
// Register map (word address; unused upper readdata bits read as zero):
//   0 DATA    debounced switch levels (read-only)
//   1 -       reserved, reads zero
//   2 IRQMASK per-bit interrupt enable (read/write)
//   3 EDGECAP captured edges (read, write-1-to-clear)

module waves_nios_switch_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  // Register addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Counter value on the last cycle of the hold window. On that cycle a
  // still-differing input is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages
  logic [WIDTH-1:0]             meta_r;
  logic [WIDTH-1:0]             sync_r;

  // Debounce state
  logic [WIDTH-1:0]             stable_r;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_r;
  logic [WIDTH-1:0]             stable_next_s;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_next_s;
  logic [WIDTH-1:0]             toggle_s;

  // Software-visible registers
  logic [WIDTH-1:0]             edgecap_r;
  logic [WIDTH-1:0]             irqmask_r;
  logic [WIDTH-1:0]             edgecap_next_s;
  logic [WIDTH-1:0]             irqmask_next_s;
  logic [WIDTH-1:0]             clear_s;

  // Bus decode
  logic                         wr_en_s;
  logic                         mask_wr_s;
  logic                         edge_wr_s;
  logic [31:0]                  readdata_next_s;

  // Two-flop synchroniser for the asynchronous switch pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= in_port;
      sync_r <= meta_r;
    end
  end

  // Per-bit debounce: count consecutive cycles the synchronised input
  // disagrees with the accepted level; any agreement restarts the window.
  always_comb begin
    stable_next_s = stable_r;
    cnt_next_s    = cnt_r;
    toggle_s      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_r[i] == stable_r[i]) begin
        cnt_next_s[i] = '0;
      end else if (cnt_r[i] == CNT_TERM) begin
        stable_next_s[i] = sync_r[i];
        toggle_s[i]      = 1'b1;
        cnt_next_s[i]    = '0;
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= '0;
      cnt_r    <= '0;
    end else begin
      stable_r <= stable_next_s;
      cnt_r    <= cnt_next_s;
    end
  end

  // Write decode; writes without chipselect are dropped
  always_comb begin
    wr_en_s   = chipselect & ~write_n;
    mask_wr_s = 1'b0;
    edge_wr_s = 1'b0;
    if (wr_en_s) begin
      case (address)
        ADDR_IRQMASK: mask_wr_s = 1'b1;
        ADDR_EDGECAP: edge_wr_s = 1'b1;
        default: begin
          mask_wr_s = 1'b0;
          edge_wr_s = 1'b0;
        end
      endcase
    end else begin
      mask_wr_s = 1'b0;
      edge_wr_s = 1'b0;
    end
  end

  // Next values for IRQMASK and EDGECAP. A newly captured edge is ORed in
  // after the clear, so a set in the same cycle as a W1C is not lost.
  always_comb begin
    if (edge_wr_s) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = '0;
    end
    edgecap_next_s = (edgecap_r & ~clear_s) | toggle_s;
    if (mask_wr_s) begin
      irqmask_next_s = writedata[WIDTH-1:0];
    end else begin
      irqmask_next_s = irqmask_r;
    end
  end

  // IRQMASK and EDGECAP registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_r <= '0;
      irqmask_r <= '0;
    end else begin
      edgecap_r <= edgecap_next_s;
      irqmask_r <= irqmask_next_s;
    end
  end

  // Read mux; runs every cycle whether or not the slave is selected
  always_comb begin
    case (address)
      ADDR_DATA:    readdata_next_s = 32'(stable_r);
      ADDR_RSVD:    readdata_next_s = 32'd0;
      ADDR_IRQMASK: readdata_next_s = 32'(irqmask_r);
      ADDR_EDGECAP: readdata_next_s = 32'(edgecap_r);
      default:      readdata_next_s = 32'd0;
    endcase
  end

  // Registered read data gives a fixed one-cycle read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= readdata_next_s;
    end
  end

  // Interrupt is a pure function of two registers, so it cannot glitch
  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: doc/waves_nios_switch_ctrl.md
# waves_nios_switch_ctrl

Avalon-MM slave controller for the board slide switches. It synchronises and debounces each switch bit, tracks changes in a per-bit edge-capture register, and raises a maskable interrupt to the Nios II. It sits between the raw `in_port` pins and the system interconnect, replacing the bare input PIO where software needs clean, event-driven switch reads.

## Interface

**Parameters**
- `WIDTH`, 8: number of switch bits (1..32).
- `DEBOUNCE_CYCLES`, 50000: cycles an input must hold a new level before it is accepted (≥2).
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: width of the per-bit debounce counter. Derived; do not override.

**Ports**
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset; asynchronous, active-low.
- `address`, input, 2: Avalon word address.
- `chipselect`, input, 1: slave select.
- `write_n`, input, 1: active-low write strobe.
- `writedata`, input, 32: write data.
- `readdata`, output, 32: registered read data.
- `in_port`, input, WIDTH: raw asynchronous switch inputs.
- `irq`, output, 1: interrupt request, active-high, level.

## Operation

**Input synchronisation**
- 2-flop synchroniser per bit, giving `sync`.

**Debounce (per bit)**
- Registers: `stable`, 1 bit, and `cnt`, CNT_W bits.
- If `sync == stable`: `cnt <= 0`.
- Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync` and `cnt <= 0`.
- Else: `cnt <= cnt + 1`.
- Any bounce back to the `stable` level before terminal count restarts the count from 0.

**Edge capture**
- On the clock edge where a bit's `stable` toggles, that bit of `edgecap` sets to 1.
- Both rising and falling edges are captured.

**Register map** (word address, upper bits of `readdata` zero-filled)
- 0 DATA: `stable`. Read-only; writes are ignored.
- 1 reserved: reads 0; writes are ignored.
- 2 IRQMASK: WIDTH bits, read/write.
- 3 EDGECAP: reads `edgecap`. A write with `chipselect=1` and `write_n=0` clears every bit set in `writedata[WIDTH-1:0]` (write-1-to-clear).

**Read path**
- `readdata` is updated every clock from `address`, independent of `chipselect`.

**Interrupt**
- `irq = |(edgecap & irqmask)`, combinational from registers, so it is glitch-free.

**Boundary conditions**
- A set and a W1C clear on the same EDGECAP bit in the same cycle: set wins, and the bit stays 1.
- A write to IRQMASK takes effect on `irq` in the cycle after the write edge.
- `chipselect=0` blocks all writes.
- Power-up edge: switches held high through reset produce a 0→1 `stable` transition D+2 cycles after reset release. This sets `edgecap`, and software clears it at init. This behaviour is intentional.
- Reset asserted mid-debounce: every register clears immediately; counting restarts after release.

**Reset values**
- `readdata`, `stable`, `cnt`, the synchroniser flops, `edgecap` and `irqmask` all reset to 0.
- Consequently `irq` is 0 during reset.

## Timing

D = `DEBOUNCE_CYCLES`. Edge numbers count from the first clock edge after `in_port` changes.

- Edge 2: `sync` reflects the new level.
- Edges 3 .. 2+D−1: `cnt` counts 1 .. D−1.
- Edge 2+D: `stable` and `edgecap` update, and `irq` asserts in the same cycle if the bit is masked in.
- Edge 3+D: `readdata` shows the new value for address 0 or 3.
- Total input-to-DATA latency is D+3 cycles.
- Read latency is 1 cycle: `readdata` is valid the cycle after `address` is presented.
- EDGECAP W1C: the bit reads 0 and `irq` deasserts after the write edge, i.e. one cycle after the write.
- No wait states; every access completes in one cycle.

## Test plan

Use D=4 and WIDTH=8 unless noted.

1. **Reset.** Hold `reset_n=0` with `in_port=8'hFF` and then release it. Required: `readdata=0` and `irq=0` during reset; DATA reads 8'hFF from edge 7 after release; EDGECAP=8'hFF.
2. **Clean edge.** From stable 8'h00, set bit 3 high and hold. Required: `stable[3]` sets at edge 6; a read of address 0 returns 32'h8 at edge 7; EDGECAP bit 3 is 1.
3. **Bounce rejection.** Toggle bit 0 high for 3 cycles, low for 1 cycle, then high and held. Required: no change at the first attempt; `stable[0]` rises exactly 6 edges after the final rising transition; only one edge is captured.
4. **Interrupt masking.** Write IRQMASK=8'h01, then generate an edge on bit 1. Required: `irq` stays 0 while EDGECAP=8'h02. Then write IRQMASK=8'h02. Required: `irq=1` in the next cycle.
5. **W1C versus set collision.** Arrange for bit 2's `stable` toggle to land on the same edge as a write of 32'h4 to address 3. Required: EDGECAP[2] remains 1. A second write of 32'h4 clears it, and `irq` drops one cycle later.
6. **Ignored writes.** Write 32'hFFFF_FFFF to addresses 0 and 1, and to address 2 with `chipselect=0`. Required: DATA is unchanged, address 1 reads 0, and IRQMASK is unchanged.
